vedic_mul_arbiter: RTL and testbench

- Shares one combinational vedic_8X8 multiplier among NUM_REQ requesters.
- Round-robin arbitration with a per-requester valid/ready handshake.
- Registers the granted operands and returns the 16-bit product on a response channel, tagged with the requester ID.
- Sits between the core request sources and the multiplier datapath; instantiates vedic_8X8 internally.

---
 rtl/vedic_mul_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_vedic_mul_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mul_arbiter.sv
// Round-robin arbiter sharing one combinational Vedic 8x8 multiplier among NUM_REQ requesters.
// Optional self-check comparator enabled by defining VEDIC_MUL_SELFCHECK_EN.

module vedic_2x2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] c_o
);
  logic t1_s, t2_s, t3_s, cy_s;

  assign t1_s   = a_i[1] & b_i[0];
  assign t2_s   = a_i[0] & b_i[1];
  assign t3_s   = a_i[1] & b_i[1];
  assign cy_s   = t1_s & t2_s;
  assign c_o[0] = a_i[0] & b_i[0];
  assign c_o[1] = t1_s ^ t2_s;
  assign c_o[2] = t3_s ^ cy_s;
  assign c_o[3] = t3_s & cy_s;
endmodule

module vedic_4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] c_o
);
  logic [3:0] q0_s, q1_s, q2_s, q3_s;

  vedic_2x2 u_ll (.a_i(a_i[1:0]), .b_i(b_i[1:0]), .c_o(q0_s));
  vedic_2x2 u_hl (.a_i(a_i[3:2]), .b_i(b_i[1:0]), .c_o(q1_s));
  vedic_2x2 u_lh (.a_i(a_i[1:0]), .b_i(b_i[3:2]), .c_o(q2_s));
  vedic_2x2 u_hh (.a_i(a_i[3:2]), .b_i(b_i[3:2]), .c_o(q3_s));

  // Urdhva-Tiryagbhyam recombination: cross products sit two bits up, high product four bits up.
  assign c_o = {4'h0, q0_s} + {2'b00, q1_s, 2'b00} + {2'b00, q2_s, 2'b00} + {q3_s, 4'h0};
endmodule

module vedic_8X8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] c_o
);
  logic [7:0] q0_s, q1_s, q2_s, q3_s;

  vedic_4x4 u_ll (.a_i(a_i[3:0]), .b_i(b_i[3:0]), .c_o(q0_s));
  vedic_4x4 u_hl (.a_i(a_i[7:4]), .b_i(b_i[3:0]), .c_o(q1_s));
  vedic_4x4 u_lh (.a_i(a_i[3:0]), .b_i(b_i[7:4]), .c_o(q2_s));
  vedic_4x4 u_hh (.a_i(a_i[7:4]), .b_i(b_i[7:4]), .c_o(q3_s));

  assign c_o = {8'h00, q0_s} + {4'h0, q1_s, 4'h0} + {4'h0, q2_s, 4'h0} + {q3_s, 8'h00};
endmodule

module vedic_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            rsp_product,
  output logic                   chk_err
);
  localparam int IW = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q;
  logic [7:0]          op_a_q, op_b_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [15:0]         rsp_product_q;
  logic [15:0]         prod_s;
  logic [NUM_REQ-1:0]  gnt_vec_s;
  logic [ID_W-1:0]     gnt_idx_s;
  logic                gnt_any_s;

  // Modular index step; the extra bit keeps the sum from overflowing before the wrap.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int unsigned off);
    logic [IW-1:0] sum;
    sum = {1'b0, base} + IW'(off);
    sum = (sum >= IW'(NUM_REQ)) ? (sum - IW'(NUM_REQ)) : sum;
    return sum[ID_W-1:0];
  endfunction

  vedic_8X8 u_mul (.a_i(op_a_q), .b_i(op_b_q), .c_o(prod_s));

  // Round-robin search for the first valid requester at or after rr_ptr.
  always_comb begin
    gnt_idx_s = '0;
    gnt_any_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any_s && req_valid[wrap_idx(rr_ptr_q, k)]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = wrap_idx(rr_ptr_q, k);
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
    gnt_vec_s = gnt_any_s ? (NUM_REQ'(1) << gnt_idx_s) : '0;
    rr_ptr_d  = wrap_idx(gnt_idx_s, 1);
  end

  // Grant is only offered while idle.
  always_comb begin
    if (state_q == IDLE) begin
      req_ready = gnt_vec_s;
    end else begin
      req_ready = '0;
    end
  end

  // Control FSM: latch operands on grant, capture product, hold response until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      op_a_q        <= 8'h00;
      op_b_q        <= 8'h00;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any_s) begin
            op_a_q   <= req_a[{gnt_idx_s, 3'b000} +: 8];
            op_b_q   <= req_b[{gnt_idx_s, 3'b000} +: 8];
            id_q     <= gnt_idx_s;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= MUL;
          end
        end
        MUL: begin
          rsp_product_q <= prod_s;
          rsp_id_q      <= id_q;
          rsp_valid_q   <= 1'b1;
          state_q       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;

`ifdef VEDIC_MUL_SELFCHECK_EN
  logic        chk_err_q;
  logic [15:0] ref_prod_s;

  assign ref_prod_s = {8'h00, op_a_q} * {8'h00, op_b_q};

  // Sticky flag: the structural multiplier disagreed with plain multiplication.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_q <= 1'b0;
    end else if ((state_q == MUL) && (prod_s != ref_prod_s)) begin
      chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Scoreboard bench for vedic_mul_arbiter: a high-level round-robin/latency model predicts grants
// and responses; a negedge monitor compares the DUT against it.

module tb_vedic_mul_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_a, req_b;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [15:0]      rsp_product;
  logic             chk_err;

  vedic_mul_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int prod; } exp_t;
  exp_t exp_q[$];

  int   total = 0;
  int   bad   = 0;
  bit   pend[N];
  int   pa[N], pb[N];
  bit   m_acc[N];
  bit   m_busy = 1'b0;
  int   m_cnt  = 0;
  int   m_rr   = 0;

  task automatic chk(string nm, longint act, longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = pend[i];
      req_a[8*i +: 8]  = pa[i][7:0];
      req_b[8*i +: 8]  = pb[i][7:0];
    end
  endtask

  task automatic issue(int i, int a, int b);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
    drive();
  endtask

  // One clock: retire requesters the model saw accepted, then re-drive.
  task automatic step();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (m_acc[i]) pend[i] = 1'b0;
      m_acc[i] = 1'b0;
    end
    drive();
  endtask

  task automatic wait_grant(int i);
    for (int c = 0; c < 20; c++) begin
      step();
      if (!pend[i]) break;
    end
    chk("grant_timeout", pend[i], 0);
  endtask

  // Monitor / reference model, evaluated mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 1'b0;
        m_cnt  = 0;
        m_rr   = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) m_acc[i] = 1'b0;
      end else begin
        int g;
        logic [N-1:0] er;
        bit exp_rv;
        g  = -1;
        er = '0;
        if (!m_busy) begin
          for (int k = 0; k < N; k++) begin
            if (g < 0 && pend[(m_rr + k) % N]) g = (m_rr + k) % N;
          end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        if (m_busy) m_cnt++;
        exp_rv = m_busy && (m_cnt >= 2);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("chk_err", chk_err, 0);
        if (rsp_valid) begin
          if (exp_q.size() > 0) begin
            chk("rsp_id", rsp_id, exp_q[0].id);
            chk("rsp_product", rsp_product, exp_q[0].prod);
          end else begin
            chk("rsp_unexpected", 1, 0);
          end
        end
        if (exp_rv && rsp_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_busy = 1'b0;
        end
        if (g >= 0) begin
          exp_t e;
          e.id   = g;
          e.prod = pa[g] * pb[g];
          exp_q.push_back(e);
          m_rr     = (g + 1) % N;
          m_busy   = 1'b1;
          m_cnt    = 0;
          m_acc[g] = 1'b1;
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pa[i] = 0; pb[i] = 0; m_acc[i] = 1'b0;
    end
    drive();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_product", rsp_product, 0);
    chk("rst_rsp_id", rsp_id, 0);
    repeat (10) step();

    // Single request with maximal operands.
    rsp_ready = 1'b1;
    issue(0, 255, 255);
    repeat (6) step();
    chk("hold_product", rsp_product, 16'hFE01);
    chk("hold_id", rsp_id, 0);

    // Round robin from a freshly reset pointer.
    rst = 1'b1;
    step();
    rst = 1'b0;
    issue(0, 5, 3);
    issue(1, 4, 2);
    issue(2, 2, 2);
    issue(3, 6, 8);
    repeat (16) step();

    // Backpressure with a competing request that must wait.
    rsp_ready = 1'b0;
    issue(1, 0, 0);
    repeat (3) step();
    issue(2, 9, 9);
    repeat (5) step();
    rsp_ready = 1'b1;
    repeat (8) step();

    // Reset while the multiply is in flight.
    issue(3, 7, 9);
    wait_grant(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_rsp_valid", rsp_valid, 0);
    issue(2, 6, 8);
    repeat (6) step();

    // Randomized traffic with boundary-biased operands and withdrawals.
    for (int c = 0; c < 500; c++) begin
      rsp_ready = ($urandom_range(9) < 7);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          int a, b;
          a = ($urandom_range(7) == 0) ? 255 : (($urandom_range(7) == 0) ? 0 : $urandom_range(255));
          b = ($urandom_range(7) == 0) ? 255 : (($urandom_range(7) == 0) ? 0 : $urandom_range(255));
          issue(i, a, b);
        end else if (pend[i] && $urandom_range(39) == 0) begin
          pend[i] = 1'b0;
          drive();
        end
      end
      step();
    end

    // Drain outstanding work.
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    for (int c = 0; c < 50; c++) begin
      step();
      if (!m_busy && exp_q.size() == 0) break;
    end
    chk("drain_outstanding", exp_q.size(), 0);
    chk("drain_busy", m_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
